seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Shares the single 4-digit 7-segment display between three pattern sources: background timer (src0), score (src1) and message overlay (src2).
- Sits between the per-source digit-to-pattern stages and the 4-digit multiplexed scan driver, and drives that driver's 32-bit input pattern.
- Fixed priority with a minimum on-screen hold time, plus optional per-source blinking.
- All timing is counted in tick pulses from the game's slow time base.

Parameters:
- HOLD_TICKS, default 3: minimum ticks an overlay (src1/src2) stays granted; 0 = no hold.
- BLINK_TICKS, default 2: ticks per blink half-period; legal range 1..255.

Ports:
- CP  input  1  system clock.
- RST_N  input  1  asynchronous, active-low reset.
- tick  input  1  one-CP-cycle time-base pulse.
- req  input  3  level requests; req[0] is ignored because src0 is always available.
- pat0  input  32  src0 pattern: 4 digits x 8 bits, low-active, bit 7 of each byte = DP.
- pat1  input  32  src1 pattern.
- pat2  input  32  src2 pattern.
- blink_en  input  3  per-source blink enable, sampled continuously.
- out_patten  output  32  registered pattern to the scan driver.
- grant  output  3  one-hot, registered, currently displayed source.
- ack  output  1  one-cycle pulse when grant changes to src1 or src2.
- busy  output  1  high while in state HOLD.

Behaviour:
- Reset (async assert, sync release): state=BG, grant=3'b001, out_patten=32'hFFFF_FFFF (blank), ack=0, busy=0, hold_cnt=0, blink_cnt=0, blink_phase=visible.
- Reset asserted mid-operation drops any overlay immediately, with no ack.
- States:
  - BG: src0 displayed.
  - HOLD: overlay granted, hold timer running.
  - RUN: overlay granted, hold expired.
- BG:
  - if req[2], grant src2; else if req[1], grant src1.
  - On either grant: next state HOLD, hold_cnt=HOLD_TICKS.
  - If HOLD_TICKS=0, next state is RUN directly.
  - ack pulses in the cycle grant changes.
- HOLD:
  - All req changes are ignored, including deassert of the granted source's own req and higher-priority requests.
  - On tick, hold_cnt decrements; a tick with hold_cnt==1 moves to RUN on the next edge.
- RUN, evaluated every cycle:
  - Granted src1 and req[2]=1: preempt to src2, enter HOLD, ack pulses.
  - Granted source's req=0 and the other overlay's req=1: switch to it, enter HOLD, ack pulses.
  - Granted source's req=0 and no other overlay req: return to BG with no ack.
  - src1 never preempts src2.
- Any grant change, including to BG, clears blink_cnt and sets blink_phase=visible.
- Blink:
  - Applies only while blink_en of the granted source is 1.
  - blink_cnt counts ticks; on a tick with blink_cnt==BLINK_TICKS-1, blink_cnt clears and blink_phase toggles.
  - Invisible phase forces out_patten=32'hFFFF_FFFF, DP bits included.
  - While blink_en of the granted source is 0, the counter still runs but the output is always visible.
- Datapath:
  - out_patten is loaded every cycle from the pattern selected by the next grant, so it has 1-cycle latency from patX to out_patten.
  - Content changes of the granted pattern pass through without an ack.
- Simultaneity:
  - A tick in the same cycle as a grant change is ignored by the new grant's counters, which start from their load values.
  - req[1] and req[2] rising in the same cycle in BG grants src2.
- Widths: hold_cnt and blink_cnt are 8 bits. HOLD_TICKS>255 is illegal.

Test Plan:
- Reset then idle with pat0=32'hC0F9A4B0 -> out_patten=32'hFFFF_FFFF during reset, 32'hC0F9A4B0 one cycle after release; grant=001, ack=0.
- req[1]=1 for one cycle only, HOLD_TICKS=3 -> ack one pulse, grant=010, busy=1; grant stays 010 for exactly 3 ticks, then returns to 001 the next cycle with no ack.
- src1 held in RUN, then req[2] rises -> grant 100 next edge, ack pulses, out_patten=pat2 one cycle later. Repeat with src2 granted and req[1] raised -> grant stays 100.
- req[2] rises during src1 HOLD -> grant unchanged until the hold expires, then switches to 100 with ack in the first RUN cycle.
- blink_en[2]=1, BLINK_TICKS=2, src2 granted -> out_patten alternates pat2 / 32'hFFFF_FFFF every 2 ticks, starting visible; clearing blink_en[2] restores pat2 next cycle.
- RST_N low asynchronously while src2 is in HOLD -> grant=001 and out blank immediately, without waiting for CP; after release, src0 pattern shows and req[2] still high is granted again with ack.

Source files
------------

// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if: source requests/patterns in, selected pattern and grant status out
interface seg_display_arbiter_if;
    logic        tick;
    logic [2:0]  req;
    logic [31:0] pat0;
    logic [31:0] pat1;
    logic [31:0] pat2;
    logic [2:0]  blink_en;
    logic [31:0] out_patten;
    logic [2:0]  grant;
    logic        ack;
    logic        busy;

    modport master (
        output tick, req, pat0, pat1, pat2, blink_en,
        input  out_patten, grant, ack, busy
    );

    modport slave (
        input  tick, req, pat0, pat1, pat2, blink_en,
        output out_patten, grant, ack, busy
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: priority arbiter with hold time and blinking for the shared 7-segment display
module seg_display_arbiter #(
    parameter int HOLD_TICKS  = 3,
    parameter int BLINK_TICKS = 2
) (
    input logic                  CP,
    input logic                  RST_N,
    seg_display_arbiter_if.slave bus
);
    typedef enum logic [1:0] {BG, HOLD, RUN} state_t;

    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_TICKS);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);
    localparam state_t     GRANT_ST   = (HOLD_TICKS == 0) ? RUN : HOLD;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  grant_nx;
    logic [7:0]  hold_cnt;
    logic [7:0]  hold_nx;
    logic [7:0]  blink_cnt;
    logic [7:0]  blink_nx;
    logic        phase;
    logic        phase_nx;
    logic        changed;
    logic [31:0] pat_sel;
    logic        unused_req0;

    assign unused_req0 = bus.req[0];

    // Grant/state decision: BG grants by priority, HOLD ignores requests, RUN preempts or releases
    always_comb begin
        state_nx = state;
        grant_nx = bus.grant;
        hold_nx  = hold_cnt;
        case (state)
            BG: begin
                if (bus.req[2] || bus.req[1]) begin
                    grant_nx = bus.req[2] ? 3'b100 : 3'b010;
                    state_nx = GRANT_ST;
                    hold_nx  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (bus.tick) begin
                    hold_nx = hold_cnt - 8'd1;
                    if (hold_cnt <= 8'd1)
                        state_nx = RUN;
                end
            end
            RUN: begin
                if (bus.grant[1] && bus.req[2]) begin
                    grant_nx = 3'b100;
                    state_nx = GRANT_ST;
                    hold_nx  = HOLD_LOAD;
                end else if (!(|(bus.req & bus.grant))) begin
                    if (bus.grant[2] ? bus.req[1] : bus.req[2]) begin
                        grant_nx = bus.grant[2] ? 3'b010 : 3'b100;
                        state_nx = GRANT_ST;
                        hold_nx  = HOLD_LOAD;
                    end else begin
                        grant_nx = 3'b001;
                        state_nx = BG;
                    end
                end
            end
            default: begin
                grant_nx = 3'b001;
                state_nx = BG;
            end
        endcase
    end

    // Blink phase tracking; a grant change restarts it visible and swallows a coincident tick
    always_comb begin
        changed  = grant_nx != bus.grant;
        blink_nx = blink_cnt;
        phase_nx = phase;
        if (changed) begin
            blink_nx = 8'd0;
            phase_nx = 1'b1;
        end else if (bus.tick) begin
            blink_nx = (blink_cnt >= BLINK_LAST) ? 8'd0 : blink_cnt + 8'd1;
            phase_nx = (blink_cnt >= BLINK_LAST) ? ~phase : phase;
        end
        pat_sel = grant_nx[2] ? bus.pat2 : grant_nx[1] ? bus.pat1 : bus.pat0;
    end

    // Registered state and outputs; output pattern follows the next grant for 1-cycle latency
    always_ff @(posedge CP or negedge RST_N) begin
        if (!RST_N) begin
            state          <= BG;
            hold_cnt       <= 8'd0;
            blink_cnt      <= 8'd0;
            phase          <= 1'b1;
            bus.grant      <= 3'b001;
            bus.ack        <= 1'b0;
            bus.busy       <= 1'b0;
            bus.out_patten <= 32'hFFFF_FFFF;
        end else begin
            state          <= state_nx;
            hold_cnt       <= hold_nx;
            blink_cnt      <= blink_nx;
            phase          <= phase_nx;
            bus.grant      <= grant_nx;
            bus.ack        <= changed && !grant_nx[0];
            bus.busy       <= state_nx == HOLD;
            bus.out_patten <= (|(bus.blink_en & grant_nx) && !phase_nx) ? 32'hFFFF_FFFF : pat_sel;
        end
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed vector table plus async-reset and pass-through sequences
module tb_seg_display_arbiter;
    localparam logic [31:0] P0 = 32'hC0F9_A4B0;
    localparam logic [31:0] P1 = 32'h1122_3344;
    localparam logic [31:0] P2 = 32'h5566_7788;
    localparam logic [31:0] BL = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        tick;
        logic [2:0]  req;
        logic [2:0]  be;
        logic [2:0]  g;
        logic        a;
        logic        b;
        logic [31:0] o;
    } vec_t;

    logic CP;
    logic RST_N;
    int   total;
    int   bad;
    vec_t v[$];

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(.HOLD_TICKS(3), .BLINK_TICKS(2)) dut (
        .CP   (CP),
        .RST_N(RST_N),
        .bus  (bus.slave)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    function automatic vec_t mk(logic t, logic [2:0] r, logic [2:0] be, logic [2:0] g,
                                logic a, logic b, logic [31:0] o);
        mk = '{t, r, be, g, a, b, o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] g, input logic a,
                           input logic b, input logic [31:0] o);
        chk({tag, " grant"}, 32'(bus.grant), 32'(g));
        chk({tag, " ack"}, 32'(bus.ack), 32'(a));
        chk({tag, " busy"}, 32'(bus.busy), 32'(b));
        chk({tag, " out"}, bus.out_patten, o);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST_N = 1'b0;
        bus.tick = 1'b0;
        bus.req = 3'b000;
        bus.blink_en = 3'b000;
        bus.pat0 = P0;
        bus.pat1 = P1;
        bus.pat2 = P2;

        v.push_back(mk(0, 3'b000, 3'b000, 3'b001, 0, 0, P0));
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 1, 1, P1));
        v.push_back(mk(0, 3'b000, 3'b000, 3'b010, 0, 1, P1));
        v.push_back(mk(1, 3'b000, 3'b000, 3'b010, 0, 1, P1));
        v.push_back(mk(1, 3'b000, 3'b000, 3'b010, 0, 1, P1));
        v.push_back(mk(1, 3'b000, 3'b000, 3'b010, 0, 0, P1));
        v.push_back(mk(0, 3'b000, 3'b000, 3'b001, 0, 0, P0));
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 1, 1, P1));
        v.push_back(mk(1, 3'b010, 3'b000, 3'b010, 0, 1, P1));
        v.push_back(mk(1, 3'b010, 3'b000, 3'b010, 0, 1, P1));
        v.push_back(mk(1, 3'b010, 3'b000, 3'b010, 0, 0, P1));
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 0, 0, P1));
        v.push_back(mk(0, 3'b110, 3'b000, 3'b100, 1, 1, P2));
        v.push_back(mk(1, 3'b110, 3'b000, 3'b100, 0, 1, P2));
        v.push_back(mk(1, 3'b110, 3'b000, 3'b100, 0, 1, P2));
        v.push_back(mk(1, 3'b110, 3'b000, 3'b100, 0, 0, P2));
        v.push_back(mk(0, 3'b110, 3'b000, 3'b100, 0, 0, P2));
        v.push_back(mk(0, 3'b010, 3'b000, 3'b010, 1, 1, P1));
        v.push_back(mk(0, 3'b110, 3'b000, 3'b010, 0, 1, P1));
        v.push_back(mk(1, 3'b110, 3'b000, 3'b010, 0, 1, P1));
        v.push_back(mk(1, 3'b110, 3'b000, 3'b010, 0, 1, P1));
        v.push_back(mk(1, 3'b110, 3'b000, 3'b010, 0, 0, P1));
        v.push_back(mk(0, 3'b110, 3'b000, 3'b100, 1, 1, P2));
        v.push_back(mk(1, 3'b100, 3'b100, 3'b100, 0, 1, P2));
        v.push_back(mk(1, 3'b100, 3'b100, 3'b100, 0, 1, BL));
        v.push_back(mk(1, 3'b100, 3'b100, 3'b100, 0, 0, BL));
        v.push_back(mk(0, 3'b100, 3'b100, 3'b100, 0, 0, BL));
        v.push_back(mk(1, 3'b100, 3'b100, 3'b100, 0, 0, P2));
        v.push_back(mk(1, 3'b100, 3'b100, 3'b100, 0, 0, P2));
        v.push_back(mk(1, 3'b100, 3'b100, 3'b100, 0, 0, BL));
        v.push_back(mk(0, 3'b100, 3'b000, 3'b100, 0, 0, P2));
        v.push_back(mk(0, 3'b100, 3'b100, 3'b100, 0, 0, BL));
        v.push_back(mk(0, 3'b000, 3'b000, 3'b001, 0, 0, P0));
        v.push_back(mk(0, 3'b100, 3'b000, 3'b100, 1, 1, P2));

        repeat (2) @(negedge CP);
        chk_all("reset", 3'b001, 1'b0, 1'b0, BL);
        RST_N = 1'b1;

        foreach (v[i]) begin
            bus.tick = v[i].tick;
            bus.req = v[i].req;
            bus.blink_en = v[i].be;
            @(posedge CP);
            @(negedge CP);
            chk_all($sformatf("v%0d", i), v[i].g, v[i].a, v[i].b, v[i].o);
        end

        bus.tick = 1'b0;
        #2 RST_N = 1'b0;
        #1 chk_all("async_rst", 3'b001, 1'b0, 1'b0, BL);
        @(negedge CP);
        RST_N = 1'b1;
        @(posedge CP);
        @(negedge CP);
        chk_all("regrant", 3'b100, 1'b1, 1'b1, P2);

        bus.pat2 = 32'h0102_0304;
        @(posedge CP);
        @(negedge CP);
        chk_all("pat_change", 3'b100, 1'b0, 1'b1, 32'h0102_0304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
